// File: rtl/rx_lock_ctrl_if.sv
// -----------------------------------------------------------------------------
// rx_lock_ctrl_if
//   Groups the DCM status input and the reset/status outputs of rx_lock_ctrl.
//   Clock and reset stay as plain ports on the module itself.
//
//   Signals:
//     locked    : DCM LOCKED, asynchronous to rxclk (driven by the DCM side)
//     dcm_rst   : active-high reset to the DCM
//     rx_rst    : active-high reset to the RX datapath
//     rx_ready  : high while the controller is in RUN (complement of rx_rst)
//     lock_lost : sticky flag, set on any lock loss from RUN
//     retry_cnt : saturating count of DCM reset retries
//
//   Modports:
//     master : the DCM / datapath side (drives locked, observes the rest)
//     slave  : the controller (observes locked, drives the rest)
// -----------------------------------------------------------------------------
interface rx_lock_ctrl_if;
  logic       locked;
  logic       dcm_rst;
  logic       rx_rst;
  logic       rx_ready;
  logic       lock_lost;
  logic [7:0] retry_cnt;

  modport master (
    output locked,
    input  dcm_rst,
    input  rx_rst,
    input  rx_ready,
    input  lock_lost,
    input  retry_cnt
  );

  modport slave (
    input  locked,
    output dcm_rst,
    output rx_rst,
    output rx_ready,
    output lock_lost,
    output retry_cnt
  );
endinterface

// File: rtl/rx_lock_ctrl.sv
// -----------------------------------------------------------------------------
// rx_lock_ctrl
//   Reset sequencer for the RX DCM. Pulses the DCM reset, waits for LOCKED with
//   a timeout/retry, requires LOCKED to stay high for STABLE_CYCLES before the
//   RX datapath reset is released, and restarts the whole sequence on any lock
//   loss. Runs on the free-running buffered input clock, never on a DCM output.
//
//   Parameters:
//     RST_CYCLES    : cycles dcm_rst is held per DCM reset pulse (1..65535)
//     LOCK_TIMEOUT  : cycles allowed waiting for lock before a retry (1..65535)
//     STABLE_CYCLES : consecutive locked cycles required before release (1..65535)
//
//   Ports:
//     rxclk : free-running buffered RX input clock
//     reset : asynchronous active-low reset
//     bus   : rx_lock_ctrl_if.slave (locked in; dcm_rst, rx_rst, rx_ready,
//             lock_lost, retry_cnt out -- all outputs registered)
// -----------------------------------------------------------------------------
module rx_lock_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256
) (
  input  logic           rxclk,
  input  logic           reset,
  rx_lock_ctrl_if.slave  bus
);

  // Terminal counts, sized to the shared 16-bit counter.
  localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);

  // Two-bit encoding uses every code point, so there is no unreachable state;
  // the default branch below still steers anything unexpected to RST_DCM.
  typedef enum logic [1:0] {
    ST_RST_DCM   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t      state_reg;
  logic [15:0] cnt_reg;
  logic [1:0]  sync_reg;
  logic        locked_s;
  logic        dcm_rst_reg;
  logic        rx_rst_reg;
  logic        rx_ready_reg;
  logic        lock_lost_reg;
  logic [7:0]  retry_cnt_reg;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous LOCKED input. Nothing else in
  // this module looks at the raw input.
  // ---------------------------------------------------------------------------
  always_ff @(posedge rxclk or negedge reset) begin
    if (!reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], bus.locked};
    end
  end

  assign locked_s = sync_reg[1];

  // ---------------------------------------------------------------------------
  // Sequencer. Outputs are assigned on the same edge as the transition that
  // changes them, so they always reflect the state being entered.
  // The shared counter clears on every transition and otherwise counts up.
  // ---------------------------------------------------------------------------
  always_ff @(posedge rxclk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_RST_DCM;
      cnt_reg       <= 16'd0;
      dcm_rst_reg   <= 1'b1;
      rx_rst_reg    <= 1'b1;
      rx_ready_reg  <= 1'b0;
      lock_lost_reg <= 1'b0;
      retry_cnt_reg <= 8'd0;
    end else begin
      case (state_reg)
        // DCM held in reset; LOCKED is meaningless here and is ignored.
        ST_RST_DCM: begin
          rx_rst_reg   <= 1'b1;
          rx_ready_reg <= 1'b0;
          if (cnt_reg == RST_LAST) begin
            state_reg   <= ST_WAIT_LOCK;
            cnt_reg     <= 16'd0;
            dcm_rst_reg <= 1'b0;
          end else begin
            cnt_reg     <= cnt_reg + 16'd1;
            dcm_rst_reg <= 1'b1;
          end
        end

        // Lock is checked before the timeout, so a lock arriving on the
        // timeout cycle still wins.
        ST_WAIT_LOCK: begin
          rx_rst_reg   <= 1'b1;
          rx_ready_reg <= 1'b0;
          if (locked_s) begin
            state_reg   <= ST_STABLE;
            cnt_reg     <= 16'd0;
            dcm_rst_reg <= 1'b0;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            state_reg     <= ST_RST_DCM;
            cnt_reg       <= 16'd0;
            dcm_rst_reg   <= 1'b1;
            retry_cnt_reg <= sat_inc(retry_cnt_reg);
          end else begin
            cnt_reg     <= cnt_reg + 16'd1;
            dcm_rst_reg <= 1'b0;
          end
        end

        // Qualification window: a dropout here is not a retry, the DCM is
        // simply given another chance to settle.
        ST_STABLE: begin
          dcm_rst_reg <= 1'b0;
          if (!locked_s) begin
            state_reg    <= ST_WAIT_LOCK;
            cnt_reg      <= 16'd0;
            rx_rst_reg   <= 1'b1;
            rx_ready_reg <= 1'b0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_reg    <= ST_RUN;
            cnt_reg      <= 16'd0;
            rx_rst_reg   <= 1'b0;
            rx_ready_reg <= 1'b1;
          end else begin
            cnt_reg      <= cnt_reg + 16'd1;
            rx_rst_reg   <= 1'b1;
            rx_ready_reg <= 1'b0;
          end
        end

        // Datapath live. Any lock loss restarts the DCM at once and counts
        // as a retry; lock_lost stays set until the next reset.
        ST_RUN: begin
          cnt_reg <= 16'd0;
          if (!locked_s) begin
            state_reg     <= ST_RST_DCM;
            dcm_rst_reg   <= 1'b1;
            rx_rst_reg    <= 1'b1;
            rx_ready_reg  <= 1'b0;
            lock_lost_reg <= 1'b1;
            retry_cnt_reg <= sat_inc(retry_cnt_reg);
          end else begin
            dcm_rst_reg  <= 1'b0;
            rx_rst_reg   <= 1'b0;
            rx_ready_reg <= 1'b1;
          end
        end

        default: begin
          state_reg    <= ST_RST_DCM;
          cnt_reg      <= 16'd0;
          dcm_rst_reg  <= 1'b1;
          rx_rst_reg   <= 1'b1;
          rx_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dcm_rst   = dcm_rst_reg;
  assign bus.rx_rst    = rx_rst_reg;
  assign bus.rx_ready  = rx_ready_reg;
  assign bus.lock_lost = lock_lost_reg;
  assign bus.retry_cnt = retry_cnt_reg;

endmodule

// File: tb/tb_rx_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_lock_ctrl
//   Directed bench. The main instance uses default parameters; a second
//   instance with LOCK_TIMEOUT = 4 exercises retry_cnt saturation.
//   For the main instance, every expected change of the output vector
//   {dcm_rst, rx_rst, rx_ready, lock_lost, retry_cnt} is queued with the edge
//   number at which it must appear; a monitor compares value and timing each
//   time the DUT outputs change.
// -----------------------------------------------------------------------------
module tb_rx_lock_ctrl;

  logic rxclk = 1'b0;
  logic reset = 1'b1;
  logic reset_sat = 1'b1;
  int unsigned cyc = 0;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;
  bit sat_done = 1'b0;

  localparam logic [11:0] RST_O = {1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

  typedef struct {
    int unsigned cyc;
    logic [11:0] o;
  } ev_t;

  ev_t         exp_q[$];
  logic [11:0] exp_o = RST_O;

  rx_lock_ctrl_if bus_main();
  rx_lock_ctrl_if bus_sat();

  rx_lock_ctrl dut (
    .rxclk (rxclk),
    .reset (reset),
    .bus   (bus_main)
  );

  rx_lock_ctrl #(.LOCK_TIMEOUT(4)) dut_sat (
    .rxclk (rxclk),
    .reset (reset_sat),
    .bus   (bus_sat)
  );

  logic [11:0] out_v;
  assign out_v = {bus_main.dcm_rst, bus_main.rx_rst, bus_main.rx_ready,
                  bus_main.lock_lost, bus_main.retry_cnt};

  always #5 rxclk = ~rxclk;
  always @(posedge rxclk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks %0d passed %0d", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Queue an expected output vector; no-op if it does not change the outputs.
  task automatic push(input int unsigned at, input logic [11:0] o);
    ev_t e;
    if (o != exp_o) begin
      e.cyc = at;
      e.o   = o;
      exp_q.push_back(e);
      $display("expect  cycle %0d outputs %03h", at, o);
    end
    exp_o = o;
  endtask

  // Advance to 2 time units after edge n (inputs change here).
  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) begin
      @(posedge rxclk);
      #2;
    end
  endtask

  // Monitor: one comparison per observed output change.
  initial begin
    logic [11:0] prev;
    ev_t e;
    prev = RST_O;
    forever begin
      @(negedge rxclk);
      if (mon_en) begin
        if (out_v !== prev) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_change: got %03h required no change (cycle %0d)", out_v, cyc);
          end else begin
            e = exp_q.pop_front();
            $display("observe cycle %0d outputs %03h", cyc, out_v);
            chk("out_value", 32'(out_v), 32'(e.o));
            chk("out_cycle", cyc, e.cyc);
          end
          prev = out_v;
        end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          n_checks++;
          $display("FAIL missed_change: got %03h required %03h at cycle %0d", out_v, e.o, e.cyc);
        end
      end
    end
  end

  // Main sequence.
  initial begin
    int unsigned r;
    int unsigned t;
    int unsigned c;
    bus_main.locked = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("reset_outputs", 32'(out_v), 32'(RST_O));
    mon_en = 1'b1;
    @(posedge rxclk);
    #2 reset = 1'b1;
    r = cyc;

    // 1: no lock -> 16-cycle pulse, 4096-cycle timeout, retry
    push(r + 16, {1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
    push(r + 16 + 4096, {1'b1, 1'b1, 1'b0, 1'b0, 8'd1});
    wait_cyc(r + 4115);

    // Reset in RST_DCM clears retry_cnt
    c = cyc;
    reset = 1'b0;
    push(c, RST_O);
    #1;
    chk("async_reset_1", 32'(out_v), 32'(RST_O));
    @(posedge rxclk);
    #2 reset = 1'b1;
    r = cyc;

    // 2: lock 100 cycles into WAIT_LOCK -> RUN 259 edges later
    push(r + 16, {1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
    wait_cyc(r + 116);
    bus_main.locked = 1'b1;
    t = cyc;
    push(t + 259, {1'b0, 1'b0, 1'b1, 1'b0, 8'd0});
    wait_cyc(t + 270);

    // 4: lock loss in RUN -> 3 edges later restart, lock_lost, retry
    bus_main.locked = 1'b0;
    c = cyc;
    push(c + 3, {1'b1, 1'b1, 1'b0, 1'b1, 8'd1});
    push(c + 19, {1'b0, 1'b1, 1'b0, 1'b1, 8'd1});
    wait_cyc(c + 19);
    bus_main.locked = 1'b1;
    t = cyc;

    // 3: 5-cycle dropout at stable count 200, no retry, RUN 259 after re-rise
    wait_cyc(t + 203);
    bus_main.locked = 1'b0;
    wait_cyc(t + 208);
    bus_main.locked = 1'b1;
    c = cyc;
    push(c + 259, {1'b0, 1'b0, 1'b1, 1'b1, 8'd1});
    wait_cyc(c + 270);

    // 6: reset in RUN, then scenario 2 again with identical timing
    c = cyc;
    reset = 1'b0;
    bus_main.locked = 1'b0;
    push(c, RST_O);
    #1;
    chk("async_reset_run", 32'(out_v), 32'(RST_O));
    @(posedge rxclk);
    #2 reset = 1'b1;
    r = cyc;
    push(r + 16, {1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
    wait_cyc(r + 116);
    bus_main.locked = 1'b1;
    t = cyc;
    push(t + 259, {1'b0, 1'b0, 1'b1, 1'b0, 8'd0});
    wait_cyc(t + 280);

    chk("queue_drained", exp_q.size(), 0);
    wait (sat_done);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // 5: saturation with LOCK_TIMEOUT = 4 (period 20 cycles, 260+ timeouts)
  initial begin
    int unsigned cs;
    int unsigned at_n  [11] = '{19, 20, 36, 40, 5099, 5100, 5180, 5195, 5196, 5200, 5300};
    int unsigned ret_x [11] = '{0, 1, 1, 2, 254, 255, 255, 255, 255, 255, 255};
    bit          dcm_x [11] = '{0, 1, 0, 1, 0, 1, 1, 1, 0, 1, 1};
    bus_sat.locked = 1'b0;
    #1 reset_sat = 1'b0;
    @(posedge rxclk);
    #2 reset_sat = 1'b1;
    cs = cyc;
    for (int i = 0; i < 11; i++) begin
      wait_cyc(cs + at_n[i]);
      $display("sat     edge %0d retry_cnt %0d dcm_rst %0b", at_n[i], bus_sat.retry_cnt, bus_sat.dcm_rst);
      chk("sat_retry_cnt", 32'(bus_sat.retry_cnt), ret_x[i]);
      chk("sat_dcm_rst", 32'(bus_sat.dcm_rst), 32'(dcm_x[i]));
    end
    sat_done = 1'b1;
  end

endmodule

// File: doc/rx_lock_ctrl.md
Name: rx_lock_ctrl

Overview:
- Sits directly downstream of the RX DCM clock generator and consumes its buffered input clock and `locked` output.
- Sequences the DCM reset, waits for lock with a timeout and retry, and qualifies lock stability.
- Drives the RX datapath reset, releasing it only after a stable lock. Any lock loss immediately re-asserts the datapath reset and restarts the DCM.
- Runs on the free-running buffered input clock, never on a DCM output clock.

Parameters:
- RST_CYCLES, 16: cycles `dcm_rst` is held high per DCM reset pulse (1..65535).
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before a retry (1..65535).
- STABLE_CYCLES, 256: consecutive synchronized-locked cycles required before RX release (1..65535).

Ports:
- rxclk, input, 1: free-running buffered RX input clock (DCM CLKIN_IBUFG output).
- reset, input, 1: asynchronous, active-low reset.
- locked, input, 1: DCM LOCKED output, asynchronous to rxclk.
- dcm_rst, output, 1: active-high reset to the DCM.
- rx_rst, output, 1: active-high reset to the RX datapath.
- rx_ready, output, 1: high while in RUN (complement of rx_rst).
- lock_lost, output, 1: sticky; set on any lock loss from RUN; cleared only by reset.
- retry_cnt, output, 8: count of DCM reset retries (timeouts plus lock losses from RUN); saturates at 255.

Behaviour:
- Reset (reset low, asynchronous) sets:
  - state = RST_DCM, counter = 0;
  - dcm_rst = 1, rx_rst = 1, rx_ready = 0;
  - lock_lost = 0, retry_cnt = 0;
  - both synchronizer flops = 0.
- `locked` passes through a 2-flop synchronizer to give locked_s. This adds 2 cycles of latency; no other logic samples raw `locked`.
- There is one shared 16-bit counter. It clears on every state transition and otherwise increments by 1 each cycle.
- All outputs are registered and update on the same edge as the state transition that causes them.
- RST_DCM:
  - dcm_rst = 1, rx_rst = 1.
  - When counter == RST_CYCLES-1, go to WAIT_LOCK.
  - dcm_rst is therefore high for exactly RST_CYCLES cycles.
  - locked_s is ignored in this state.
- WAIT_LOCK:
  - dcm_rst = 0, rx_rst = 1.
  - If locked_s = 1, go to STABLE.
  - Else, if counter == LOCK_TIMEOUT-1, go to RST_DCM and increment retry_cnt (saturating).
  - If locked_s rises on the timeout cycle, lock wins and the state goes to STABLE.
- STABLE:
  - dcm_rst = 0, rx_rst = 1.
  - If locked_s = 0, return to WAIT_LOCK with the counter cleared and no retry increment.
  - Else, if counter == STABLE_CYCLES-1, go to RUN; on that edge rx_rst drops to 0 and rx_ready rises to 1.
- RUN:
  - dcm_rst = 0, rx_rst = 0, rx_ready = 1.
  - The counter is held at 0.
  - If locked_s = 0, go to RST_DCM on the next edge. On that edge: rx_rst = 1, rx_ready = 0, dcm_rst = 1, lock_lost = 1, retry_cnt incremented (saturating).
- Latency from raw `locked` rising (given WAIT_LOCK) to rx_rst falling is exactly STABLE_CYCLES+3 edges.
- Latency from raw `locked` falling in RUN to rx_rst rising is exactly 3 edges.
- A `locked` glitch shorter than 1 cycle may be missed. Any glitch captured by the synchronizer is treated as a real transition.
- retry_cnt saturates at 255: further retries leave it at 255, and the retry sequencing itself continues indefinitely.
- Asserting reset mid-operation (any state) immediately forces all reset values asynchronously. After release, the sequence restarts from RST_DCM with a full RST_CYCLES pulse.
- There are no illegal states. Any unused encoding decodes to RST_DCM.

Test Plan:
1. Release reset with `locked` = 0 held; defaults → dcm_rst high for exactly 16 cycles; then WAIT_LOCK; after 4096 cycles dcm_rst re-asserts and retry_cnt = 1; rx_rst stays 1 throughout.
2. After the first dcm_rst pulse, raise `locked` 100 cycles into WAIT_LOCK and hold it → rx_rst falls and rx_ready rises exactly 259 edges after `locked` rises; retry_cnt = 0; lock_lost = 0.
3. In STABLE, drop `locked` for 5 cycles at stable count 200, then re-raise it → return to WAIT_LOCK with no retry increment; rx_rst falls 259 edges after the second rise.
4. In RUN, drop `locked` → 3 edges later rx_rst = 1, rx_ready = 0, dcm_rst = 1 (for 16 cycles), lock_lost = 1, retry_cnt = 1. Re-locking reaches RUN again with lock_lost still 1.
5. Force 260 consecutive timeouts (`locked` = 0, with LOCK_TIMEOUT overridden to 4 for simulation speed) → retry_cnt = 255 and stays 255; dcm_rst pulses continue every 16+4 cycles.
6. Assert reset for 1 cycle while in RUN → rx_rst = 1, dcm_rst = 1, lock_lost = 0, retry_cnt = 0 asynchronously; the full sequence then repeats from scenario 2 with identical timing.
